// File: rtl/boot_rom_copier.sv
`default_nettype none
// ============================================================================
// boot_rom_copier: copies a word range from boot ROM into data RAM, summing it
// Revision: 1.0
// ============================================================================
module boot_rom_copier #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   input  logic [ADDR_WIDTH-1:0] word_count,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_write_enable,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state;
   state_t                state_next;

   logic [ADDR_WIDTH-3:0] src_word;
   logic [ADDR_WIDTH-3:0] dst_word;
   logic [ADDR_WIDTH-1:0] count;
   logic [ADDR_WIDTH-1:0] index;
   logic [ADDR_WIDTH-1:0] index_inc;
   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] rom_addr_cur;
   logic [ADDR_WIDTH-1:0] ram_addr_cur;
   logic [ADDR_WIDTH-1:0] rom_address_hold;
   logic [ADDR_WIDTH-1:0] ram_address_hold;
   logic [DATA_WIDTH-1:0] ram_data_hold;
   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] sum;
   logic                  unused;

   // Byte-lane bits of the base addresses carry no information for word copies.
   assign unused = ^{src_base[1:0], dst_base[1:0]};

   assign index_inc    = index + ADDR_WIDTH'(1);
   assign offset       = {index[ADDR_WIDTH-3:0], 2'b00};
   assign rom_addr_cur = {src_word, 2'b00} + offset;
   assign ram_addr_cur = {dst_word, 2'b00} + offset;

   // Address/data ports show the live value in their own state and hold otherwise.
   assign rom_address = (state == FETCH) ? rom_addr_cur : rom_address_hold;
   assign ram_address = (state == WRITE) ? ram_addr_cur : ram_address_hold;
   assign ram_data    = (state == WRITE) ? data         : ram_data_hold;
   assign checksum    = sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      busy             = 1'b0;
      done             = 1'b0;
      ram_write_enable = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (word_count == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            busy       = 1'b1;
            state_next = WRITE;
         end
         WRITE: begin
            busy             = 1'b1;
            ram_write_enable = 1'b1;
            state_next       = (index_inc == count) ? DONE : FETCH;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_word         <= '0;
         dst_word         <= '0;
         count            <= '0;
         index            <= '0;
         data             <= '0;
         sum              <= '0;
         rom_address_hold <= '0;
         ram_address_hold <= '0;
         ram_data_hold    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_word <= src_base[ADDR_WIDTH-1:2];
                  dst_word <= dst_base[ADDR_WIDTH-1:2];
                  count    <= word_count;
                  index    <= '0;
                  sum      <= '0;
               end
            end
            FETCH: begin
               data             <= rom_data;
               rom_address_hold <= rom_addr_cur;
            end
            WRITE: begin
               sum              <= sum + data;
               index            <= index_inc;
               ram_address_hold <= ram_addr_cur;
               ram_data_hold    <= data;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_boot_rom_copier.sv
`default_nettype none
// tb_boot_rom_copier: directed self-checking bench for boot_rom_copier.
module tb_boot_rom_copier;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] src_base;
   logic [15:0] dst_base;
   logic [15:0] word_count;
   logic [15:0] rom_address;
   logic [31:0] rom_data;
   logic [15:0] ram_address;
   logic [31:0] ram_data;
   logic        ram_write_enable;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   logic [31:0] rom_words [0:15];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int base     = 0;
   int wr0      = 0;
   int dn0      = 0;

   // Written only by the negedge monitor.
   int          n_wr      = 0;
   int          done_cnt  = 0;
   int          done_rel  = 0;
   int          done_busy = 0;
   int          consec    = 0;
   logic        prev_we   = 1'b0;
   logic [15:0] wr_addr [0:63];
   logic [31:0] wr_data [0:63];
   int          wr_cyc  [0:63];

   boot_rom_copier #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .src_base         (src_base),
      .dst_base         (dst_base),
      .word_count       (word_count),
      .rom_address      (rom_address),
      .rom_data         (rom_data),
      .ram_address      (ram_address),
      .ram_data         (ram_data),
      .ram_write_enable (ram_write_enable),
      .busy             (busy),
      .done             (done),
      .checksum         (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Combinational ROM: a 16-word table at the bottom, address-derived data above.
   assign rom_data = (rom_address[15:6] == 10'd0) ? rom_words[rom_address[5:2]]
                                                  : {rom_address, ~rom_address};

   always @(negedge clk) begin
      if (ram_write_enable) begin
         if (n_wr < 64) begin
            wr_addr[n_wr] = ram_address;
            wr_data[n_wr] = ram_data;
            wr_cyc[n_wr]  = cyc - base + 1;
         end
         n_wr = n_wr + 1;
         if (prev_we) consec = consec + 1;
      end
      prev_we = ram_write_enable;
      if (done) begin
         done_rel  = cyc - base + 1;
         done_busy = int'(busy);
         done_cnt  = done_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rom_sum(input int first, input int n);
      logic [31:0] s = 32'd0;
      for (int i = 0; i < n; i++) s = s + rom_words[first + i];
      return s;
   endfunction

   task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
      src_base   = s;
      dst_base   = d;
      word_count = c;
      start      = 1'b1;
      wr0        = n_wr;
      dn0        = done_cnt;
   endtask

   // Steps past the accepting edge, then waits (bounded) for the done pulse.
   task automatic wait_done(input int max_cyc, input int pulse_at);
      bit seen = 1'b0;
      @(posedge clk); #1;
      base  = cyc;
      start = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         start = (i == pulse_at);
         if (i == pulse_at) begin
            src_base   = 16'h5550;
            dst_base   = 16'h7770;
            word_count = 16'd9;
         end
         if (done_cnt != dn0) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rom_words[0]  = 32'h82BF7857;
      rom_words[1]  = 32'hFCACD0A9;
      rom_words[2]  = 32'h1234ABCD;
      rom_words[3]  = 32'hFAFF41FE;
      rom_words[4]  = 32'h0BADF00D;
      rom_words[5]  = 32'hDEADBEEF;
      rom_words[6]  = 32'hC0FFEE11;
      rom_words[7]  = 32'h9F7A8229;
      rom_words[8]  = 32'h11111111;
      rom_words[9]  = 32'h22222222;
      for (int i = 10; i < 16; i++) rom_words[i] = 32'h01010101 * i;

      reset      = 1'b1;
      start      = 1'b0;
      src_base   = 16'd0;
      dst_base   = 16'd0;
      word_count = 16'd0;

      // Scenario 1/2: start held through reset, copy begins after release.
      @(posedge clk); #1;
      launch(16'h0000, 16'h0100, 16'd2);
      repeat (2) @(posedge clk);
      #1;
      check("rst_rom_address", {16'd0, rom_address}, 32'd0);
      check("rst_ram_address", {16'd0, ram_address}, 32'd0);
      check("rst_ram_data", ram_data, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      check("rst_flags", {29'd0, busy, done, ram_write_enable}, 32'd0);
      check("rst_no_writes", n_wr, 32'd0);
      reset = 1'b0;
      wait_done(20, -1);
      check("s2_nwrites", n_wr - wr0, 32'd2);
      check("s2_addr0", {16'd0, wr_addr[wr0]}, 32'h0100);
      check("s2_data0", wr_data[wr0], 32'h82BF7857);
      check("s2_cyc0", wr_cyc[wr0], 32'd2);
      check("s2_addr1", {16'd0, wr_addr[wr0+1]}, 32'h0104);
      check("s2_data1", wr_data[wr0+1], 32'hFCACD0A9);
      check("s2_cyc1", wr_cyc[wr0+1], 32'd4);
      check("s2_done_cyc", done_rel, 32'd5);
      check("s2_checksum", checksum, 32'h7F6C4900);
      check("s2_busy_after", {31'd0, busy}, 32'd0);
      check("s2_rom_addr_hold", {16'd0, rom_address}, 32'h0004);
      check("s2_ram_addr_hold", {16'd0, ram_address}, 32'h0104);

      // Scenario 3: ROM words 3..7.
      launch(16'h000C, 16'h0200, 16'd5);
      wait_done(40, -1);
      check("s3_nwrites", n_wr - wr0, 32'd5);
      check("s3_addr0", {16'd0, wr_addr[wr0]}, 32'h0200);
      check("s3_data0", wr_data[wr0], 32'hFAFF41FE);
      check("s3_addr4", {16'd0, wr_addr[wr0+4]}, 32'h0210);
      check("s3_data4", wr_data[wr0+4], 32'h9F7A8229);
      check("s3_cyc4", wr_cyc[wr0+4], 32'd10);
      check("s3_done_cyc", done_rel, 32'd11);
      check("s3_checksum", checksum, rom_sum(3, 5));

      // Scenario 4: empty copy, byte bits of src ignored.
      launch(16'h0003, 16'h0300, 16'd0);
      wait_done(10, -1);
      check("s4_done_cyc", done_rel, 32'd1);
      check("s4_busy_with_done", done_busy, 32'd1);
      check("s4_nwrites", n_wr - wr0, 32'd0);
      check("s4_checksum", checksum, 32'd0);

      // Scenario 5: destination wraps past 0xFFFF; dst byte bits ignored.
      launch(16'h0020, 16'hFFFE, 16'd2);
      wait_done(20, -1);
      check("s5_nwrites", n_wr - wr0, 32'd2);
      check("s5_addr0", {16'd0, wr_addr[wr0]}, 32'hFFFC);
      check("s5_data0", wr_data[wr0], 32'h11111111);
      check("s5_addr1", {16'd0, wr_addr[wr0+1]}, 32'h0000);
      check("s5_data1", wr_data[wr0+1], 32'h22222222);
      check("s5_checksum", checksum, 32'h33333333);

      // Scenario 6a: start pulsed mid-run with new parameters is ignored.
      launch(16'h0000, 16'h0400, 16'd3);
      wait_done(30, 1);
      check("s6a_nwrites", n_wr - wr0, 32'd3);
      check("s6a_addr2", {16'd0, wr_addr[wr0+2]}, 32'h0408);
      check("s6a_data2", wr_data[wr0+2], 32'h1234ABCD);
      check("s6a_done_cyc", done_rel, 32'd7);
      check("s6a_checksum", checksum, rom_sum(0, 3));
      repeat (3) @(posedge clk);
      #1;
      check("s6a_no_restart", {31'd0, busy}, 32'd0);
      check("s6a_no_extra_wr", n_wr - wr0, 32'd3);

      // Scenario 6b: reset after the first write of a 4-word run.
      launch(16'h0000, 16'h0500, 16'd4);
      @(posedge clk); #1;
      base  = cyc;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (n_wr != wr0) break;
         @(posedge clk); #1;
      end
      check("s6b_first_write", n_wr - wr0, 32'd1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("s6b_nwrites", n_wr - wr0, 32'd1);
      check("s6b_no_done", done_cnt - dn0, 32'd0);
      check("s6b_idle", {31'd0, busy}, 32'd0);
      check("s6b_checksum", checksum, 32'd0);

      check("we_never_back_to_back", consec, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
